// File: rtl/kernel_2mm_avmm_responder.sv
// Fixed-latency Avalon-MM responder backed by a word memory, for the kernel_2mm 64-bit master.
// It never stalls. Reads return after READ_LATENCY cycles, and out-of-window and collision events are logged.
module kernel_2mm_avmm_responder #(
   parameter logic [63:0] BASE_ADDR    = 64'h0,
   parameter int          DEPTH_WORDS  = 4096,
   parameter int          READ_LATENCY = 2
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [63:0] avs_address,
   input  logic [7:0]  avs_byteenable,
   input  logic        avs_read,
   output logic [63:0] avs_readdata,
   output logic        avs_readdatavalid,
   input  logic        avs_write,
   input  logic [63:0] avs_writedata,
   output logic [15:0] err_count,
   output logic [63:0] err_addr,
   output logic        err_flag
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [63:0] WIN_BYTES = 64'(DEPTH_WORDS) * 64'd8;

   logic [63:0]   offset;
   logic          in_window;
   logic [AW-1:0] idx;
   logic          wr_en;
   logic          rd_acc;
   logic          err_evt;

   assign offset    = avs_address - BASE_ADDR;
   assign in_window = (avs_address >= BASE_ADDR) && (offset < WIN_BYTES);
   assign idx       = offset[AW+2:3];
   assign wr_en     = avs_write & in_window;
   assign rd_acc    = avs_read & ~avs_write;
   // A read colliding with a write is one event, even when the write is also out of window.
   assign err_evt   = ((avs_read | avs_write) & ~in_window) | (avs_read & avs_write);

   // Memory has no reset so its contents survive a reset pulse.
   logic [63:0] mem [DEPTH_WORDS];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < 8; i++) begin
            if (avs_byteenable[i]) mem[idx][8*i +: 8] <= avs_writedata[8*i +: 8];
         end
      end
   end

   logic [READ_LATENCY:1]        vld_pipe_q, vld_pipe_d;
   logic [READ_LATENCY:1][63:0]  rd_pipe_q,  rd_pipe_d;
   logic [15:0]                  err_count_q, err_count_d;
   logic [63:0]                  err_addr_q,  err_addr_d;
   logic                         err_flag_q,  err_flag_d;

   // Data stages load only behind a valid bit, so the output holds between reads.
   always_comb begin
      vld_pipe_d    = vld_pipe_q;
      rd_pipe_d     = rd_pipe_q;
      vld_pipe_d[1] = rd_acc;
      if (rd_acc) rd_pipe_d[1] = in_window ? mem[idx] : 64'h0;
      for (int k = 2; k <= READ_LATENCY; k++) begin
         vld_pipe_d[k] = vld_pipe_q[k-1];
         if (vld_pipe_q[k-1]) rd_pipe_d[k] = rd_pipe_q[k-1];
      end
   end

   always_comb begin
      err_count_d = err_count_q;
      err_addr_d  = err_addr_q;
      err_flag_d  = err_flag_q;
      if (err_evt) begin
         if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
         if (!err_flag_q) begin
            err_flag_d = 1'b1;
            err_addr_d = avs_address;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         vld_pipe_q  <= '0;
         rd_pipe_q   <= '0;
         err_count_q <= 16'h0;
         err_addr_q  <= 64'h0;
         err_flag_q  <= 1'b0;
      end else begin
         vld_pipe_q  <= vld_pipe_d;
         rd_pipe_q   <= rd_pipe_d;
         err_count_q <= err_count_d;
         err_addr_q  <= err_addr_d;
         err_flag_q  <= err_flag_d;
      end
   end

   assign avs_readdata      = rd_pipe_q[READ_LATENCY];
   assign avs_readdatavalid = vld_pipe_q[READ_LATENCY];
   assign err_count         = err_count_q;
   assign err_addr          = err_addr_q;
   assign err_flag          = err_flag_q;

endmodule
